// File: rtl/pwm_gen.sv
// PWM generator paced by a synchronized divided-clock tick; period/duty are
// shadowed and only reloaded at a period wrap so the waveform never glitches.
module pwm_gen #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             div_in,
   input  logic             en,
   input  logic [WIDTH-1:0] period,
   input  logic [WIDTH-1:0] duty,
   output logic             pwm_out,
   output logic             period_done
);

   typedef enum logic {IDLE, RUN} state_t;

   logic             s1_q, s2_q, s3_q;
   logic             s1_d, s2_d, s3_d;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] period_r_q, period_r_d;
   logic [WIDTH-1:0] duty_r_q, duty_r_d;
   logic             pwm_q, pwm_d;
   logic             done_q, done_d;
   logic             tick;

   // s3 is a delayed copy of the synchronized level, used only for edge detection
   assign tick = s2_q & ~s3_q;

   always_comb begin
      s1_d       = div_in;
      s2_d       = s1_q;
      s3_d       = s2_q;
      state_d    = state_q;
      cnt_d      = cnt_q;
      period_r_d = period_r_q;
      duty_r_d   = duty_r_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (en && tick) begin
               state_d    = RUN;
               period_r_d = period;
               duty_r_d   = duty;
            end
         end
         RUN: begin
            // Disable wins over a coincident wrap, so no period_done on shutdown
            if (!en) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (tick) begin
               if (cnt_q == period_r_q) begin
                  cnt_d      = '0;
                  period_r_d = period;
                  duty_r_d   = duty;
                  done_d     = 1'b1;
               end else begin
                  cnt_d = cnt_q + WIDTH'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Compare against next-state values so pwm_out lines up with cnt
      pwm_d = (state_d == RUN) && (cnt_d < duty_r_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         s3_q       <= 1'b0;
         state_q    <= IDLE;
         cnt_q      <= '0;
         period_r_q <= '0;
         duty_r_q   <= '0;
         pwm_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         s3_q       <= s3_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         period_r_q <= period_r_d;
         duty_r_q   <= duty_r_d;
         pwm_q      <= pwm_d;
         done_q     <= done_d;
      end
   end

   assign pwm_out     = pwm_q;
   assign period_done = done_q;

endmodule
